// File: rtl/pending_instr_tracker_pkg.sv
// Shared constants for the pending-instruction tracker and its users.
//   PIT_CTR_WIDTH : default bits per warp counter
//   PIT_ALM_EMPTY : pending count at which a warp reports "almost empty";
//                   the CSR unit imports the same value so both agree that the
//                   querying CSR instruction itself is the one still in flight.
//   pit_idx_bits  : width of a warp index for a given warp count (min 1 bit)
package pending_instr_tracker_pkg;

    localparam int unsigned PIT_CTR_WIDTH = 8;
    localparam int unsigned PIT_ALM_EMPTY = 1;

    function automatic int unsigned pit_idx_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pending_commit_popcount.sv
// Counts how many commit ports retire an instruction for one target warp.
//   commit_valid_i : per-port commit fire
//   commit_wid_i   : packed per-port warp ids, port p at [p*NW_WIDTH +: NW_WIDTH]
//   target_wid_i   : warp this instance counts for
//   decr_o         : number of ports retiring target_wid_i this cycle
module pending_commit_popcount
    import pending_instr_tracker_pkg::*;
#(
    parameter int unsigned NUM_COMMITS = 2,
    parameter int unsigned NW_WIDTH    = 2,
    parameter int unsigned DEC_WIDTH   = $clog2(NUM_COMMITS + 1)
) (
    input  logic [NUM_COMMITS-1:0]          commit_valid_i,
    input  logic [NUM_COMMITS*NW_WIDTH-1:0] commit_wid_i,
    input  logic [NW_WIDTH-1:0]             target_wid_i,
    output logic [DEC_WIDTH-1:0]            decr_o
);

    always_comb begin
        decr_o = '0;
        for (int unsigned p = 0; p < NUM_COMMITS; p++) begin
            if (commit_valid_i[p] && (commit_wid_i[p*NW_WIDTH +: NW_WIDTH] == target_wid_i)) begin
                decr_o = decr_o + DEC_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/pending_instr_tracker.sv
// Per-warp count of instructions issued to execute and not yet committed.
//   clk, reset     : clock, synchronous active-low reset
//   issue_valid/_wid, issue_ready : issue handshake; ready drops only when the
//                    addressed warp's counter is saturated and nothing retires
//                    for that warp this cycle
//   commit_valid/_wid : NUM_COMMITS retire ports (packed warp ids)
//   alm_empty_wid/alm_empty : combinational "pending == ALM_EMPTY" query
//   empty_mask, busy : registered per-warp zero flags / any-nonzero flag
//   underflow_err  : sticky, a commit arrived for a warp with too few pending
module pending_instr_tracker
    import pending_instr_tracker_pkg::*;
#(
    parameter int unsigned NUM_WARPS   = 4,
    parameter int unsigned NUM_COMMITS = 2,
    parameter int unsigned CTR_WIDTH   = PIT_CTR_WIDTH,
    parameter int unsigned ALM_EMPTY   = PIT_ALM_EMPTY,
    localparam int unsigned NW_WIDTH   = pit_idx_bits(NUM_WARPS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            issue_valid,
    input  logic [NW_WIDTH-1:0]             issue_wid,
    output logic                            issue_ready,
    input  logic [NUM_COMMITS-1:0]          commit_valid,
    input  logic [NUM_COMMITS*NW_WIDTH-1:0] commit_wid,
    input  logic [NW_WIDTH-1:0]             alm_empty_wid,
    output logic                            alm_empty,
    output logic [NUM_WARPS-1:0]            empty_mask,
    output logic                            busy,
    output logic                            underflow_err
);

    localparam int unsigned DEC_WIDTH = $clog2(NUM_COMMITS + 1);
    localparam int unsigned EXT_WIDTH = CTR_WIDTH + 1;

    logic [CTR_WIDTH-1:0] pending_q [NUM_WARPS];
    logic [CTR_WIDTH-1:0] pending_d [NUM_WARPS];
    logic [DEC_WIDTH-1:0] decr      [NUM_WARPS];
    logic [NUM_WARPS-1:0] empty_q, empty_d;
    logic [NUM_WARPS-1:0] uflow_d;
    logic                 busy_q;
    logic                 err_q;
    logic                 sel_full, sel_hit, issue_fire;
    logic [EXT_WIDTH-1:0] cur, dec, inc, sum;

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_pop
        pending_commit_popcount #(
            .NUM_COMMITS (NUM_COMMITS),
            .NW_WIDTH    (NW_WIDTH),
            .DEC_WIDTH   (DEC_WIDTH)
        ) u_pop (
            .commit_valid_i (commit_valid),
            .commit_wid_i   (commit_wid),
            .target_wid_i   (NW_WIDTH'(w)),
            .decr_o         (decr[w])
        );
    end

    // Select the issuing warp by comparison rather than indexing, so warp ids
    // beyond NUM_WARPS-1 (non power-of-two configs) never index out of range.
    always_comb begin
        sel_full  = 1'b0;
        sel_hit   = 1'b0;
        alm_empty = 1'b0;
        for (int unsigned w = 0; w < NUM_WARPS; w++) begin
            if (issue_wid == NW_WIDTH'(w)) begin
                sel_full = (pending_q[w] == '1);
                sel_hit  = (decr[w] != '0);
            end
            if (alm_empty_wid == NW_WIDTH'(w)) begin
                alm_empty = (pending_q[w] == CTR_WIDTH'(ALM_EMPTY));
            end
        end
    end

    assign issue_ready = !sel_full || sel_hit;
    assign issue_fire  = issue_valid && issue_ready;

    // Retirements are taken first and clamped at zero, then the issue is added,
    // so an issue is never lost even in an underflow cycle.
    always_comb begin
        pending_d = pending_q;
        empty_d   = '0;
        uflow_d   = '0;
        cur       = '0;
        dec       = '0;
        inc       = '0;
        sum       = '0;
        for (int unsigned w = 0; w < NUM_WARPS; w++) begin
            cur = {1'b0, pending_q[w]};
            dec = EXT_WIDTH'(decr[w]);
            inc = EXT_WIDTH'(issue_fire && (issue_wid == NW_WIDTH'(w)));
            if (dec > cur) begin
                uflow_d[w] = 1'b1;
                sum        = inc;
            end else begin
                sum = cur - dec + inc;
            end
            pending_d[w] = sum[CTR_WIDTH-1:0];
            empty_d[w]   = (sum[CTR_WIDTH-1:0] == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned w = 0; w < NUM_WARPS; w++) begin
                pending_q[w] <= '0;
            end
            empty_q <= '1;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            for (int unsigned w = 0; w < NUM_WARPS; w++) begin
                pending_q[w] <= pending_d[w];
                assert (!uflow_d[w])
                    else $warning("pending_instr_tracker: commit on empty counter, warp %0d", w);
            end
            empty_q <= empty_d;
            busy_q  <= !(&empty_d);
            err_q   <= err_q || (|uflow_d);
        end
    end

    assign empty_mask    = empty_q;
    assign busy          = busy_q;
    assign underflow_err = err_q;

endmodule

// File: tb/tb_pending_instr_tracker.sv
module tb_pending_instr_tracker;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       issue_valid = 1'b0;
    logic [1:0] issue_wid = '0;
    logic [1:0] commit_valid = '0;
    logic [3:0] commit_wid = '0;
    logic [1:0] alm_empty_wid = '0;

    logic       ready_a, alm_a, busy_a, err_a;
    logic [3:0] empty_a;
    logic       ready_b, alm_b, busy_b, err_b;
    logic [3:0] empty_b;

    always #5 clk = ~clk;

    pending_instr_tracker #(.NUM_WARPS(4), .NUM_COMMITS(2), .CTR_WIDTH(8), .ALM_EMPTY(1)) dut_a (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_wid(issue_wid),
        .issue_ready(ready_a), .commit_valid(commit_valid), .commit_wid(commit_wid),
        .alm_empty_wid(alm_empty_wid), .alm_empty(alm_a), .empty_mask(empty_a),
        .busy(busy_a), .underflow_err(err_a));

    pending_instr_tracker #(.NUM_WARPS(4), .NUM_COMMITS(2), .CTR_WIDTH(2), .ALM_EMPTY(1)) dut_b (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_wid(issue_wid),
        .issue_ready(ready_b), .commit_valid(commit_valid), .commit_wid(commit_wid),
        .alm_empty_wid(alm_empty_wid), .alm_empty(alm_b), .empty_mask(empty_b),
        .busy(busy_b), .underflow_err(err_b));

    int n_total = 0;
    int n_pass  = 0;
    bit check_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        else n_pass++;
    endtask

    // Behavioural model: k=0 mirrors dut_a (max 255), k=1 mirrors dut_b (max 3).
    int pend [2][4];
    bit merr [2];
    int maxv [2] = '{255, 3};

    function automatic int ndec(input int w);
        int n = 0;
        for (int p = 0; p < 2; p++)
            if (commit_valid[p] && commit_wid[p*2 +: 2] == 2'(w)) n++;
        return n;
    endfunction

    function automatic bit mready(input int k);
        return !(pend[k][issue_wid] == maxv[k] && ndec(int'(issue_wid)) == 0);
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                for (int w = 0; w < 4; w++) pend[k][w] = 0;
                merr[k] = 1'b0;
            end else begin
                bit fire;
                fire = issue_valid && mready(k);
                for (int w = 0; w < 4; w++) begin
                    int inc, d;
                    inc = (fire && issue_wid == 2'(w)) ? 1 : 0;
                    d   = ndec(w);
                    if (d > pend[k][w]) begin
                        merr[k]    = 1'b1;
                        pend[k][w] = inc;
                    end else begin
                        pend[k][w] = pend[k][w] - d + inc;
                    end
                end
            end
        end
    end

    task automatic cmp(input int k, input logic r, input logic a, input logic [3:0] e,
                       input logic b, input logic er);
        logic [3:0] em;
        for (int w = 0; w < 4; w++) em[w] = (pend[k][w] == 0);
        chk($sformatf("dut%0d issue_ready", k), r, mready(k));
        chk($sformatf("dut%0d alm_empty", k), a, pend[k][alm_empty_wid] == 1);
        chk($sformatf("dut%0d empty_mask", k), e, em);
        chk($sformatf("dut%0d busy", k), b, em != 4'b1111);
        chk($sformatf("dut%0d underflow_err", k), er, merr[k]);
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            cmp(0, ready_a, alm_a, empty_a, busy_a, err_a);
            cmp(1, ready_b, alm_b, empty_b, busy_b, err_b);
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        issue_valid  = 1'b0;
        commit_valid = '0;
        commit_wid   = '0;
    endtask

    initial begin
        // Reset then idle
        reset = 1'b0;
        tick();
        check_en = 1'b1;
        tick();
        reset = 1'b1;
        chk("reset empty_mask", empty_a, 4'b1111);
        chk("reset busy", busy_a, 0);
        chk("reset issue_ready", ready_a, 1);
        for (int w = 0; w < 4; w++) begin
            alm_empty_wid = 2'(w);
            #1;
            chk($sformatf("reset alm_empty w%0d", w), alm_a, 0);
        end
        tick();

        // Single warp round trip on warp 2
        issue_valid = 1'b1; issue_wid = 2'd2;
        tick(3);
        idle();
        alm_empty_wid = 2'd2;
        #1;
        chk("w2 count 3 alm_empty", alm_a, 0);
        chk("model w2 count", pend[0][2], 3);
        commit_valid = 2'b01; commit_wid = {2'd0, 2'd2};
        tick(2);
        idle();
        #1;
        chk("w2 count 1 alm_empty", alm_a, 1);
        chk("model w2 count 1", pend[0][2], 1);
        commit_valid = 2'b01; commit_wid = {2'd0, 2'd2};
        tick();
        idle();
        chk("w2 drained empty_mask", empty_a[2], 1);
        chk("w2 drained busy", busy_a, 0);

        // Concurrent issue and double commit on warp 1 at count 3
        issue_valid = 1'b1; issue_wid = 2'd1;
        tick(3);
        commit_valid = 2'b11; commit_wid = {2'd1, 2'd1};
        tick();
        idle();
        chk("model w1 net", pend[0][1], 2);
        chk("model_b w1 net", pend[1][1], 2);
        issue_valid = 1'b1; issue_wid = 2'd0;
        tick(2);
        idle();
        commit_valid = 2'b11; commit_wid = {2'd0, 2'd0};
        tick();
        idle();
        chk("w0 double commit empty_mask", empty_a, 4'b1101);
        commit_valid = 2'b11; commit_wid = {2'd1, 2'd1};
        tick();
        idle();
        chk("all drained busy", busy_a, 0);

        // Saturation backpressure (dut_b, CTR_WIDTH=2)
        issue_valid = 1'b1; issue_wid = 2'd0;
        tick(3);
        #1;
        chk("sat b ready w0", ready_b, 0);
        chk("sat a ready w0", ready_a, 1);
        issue_valid = 1'b0; issue_wid = 2'd3;
        #1;
        chk("sat b ready w3", ready_b, 1);
        issue_valid = 1'b1; issue_wid = 2'd0;
        tick();
        chk("model_b held at max", pend[1][0], 3);
        commit_valid = 2'b01; commit_wid = {2'd0, 2'd0};
        #1;
        chk("sat b ready with commit", ready_b, 1);
        tick();
        chk("model_b stays 3", pend[1][0], 3);
        chk("model_a w0 4", pend[0][0], 4);
        chk("sat b empty_mask w0", empty_b[0], 0);
        issue_valid = 1'b0;
        tick(3);
        idle();
        chk("model_b w0 drained", pend[1][0], 0);

        // Underflow on warp 3
        commit_valid = 2'b10; commit_wid = {2'd3, 2'd0};
        tick();
        idle();
        chk("underflow err a", err_a, 1);
        chk("underflow err b", err_b, 1);
        chk("underflow w3 empty", empty_a[3], 1);
        chk("model w3 clamped", pend[0][3], 0);
        issue_valid = 1'b1; issue_wid = 2'd3;
        tick();
        issue_wid = 2'd0;
        tick();
        issue_wid = 2'd2;
        tick(5);
        idle();
        chk("underflow sticky", err_a, 1);
        chk("counts {2,0,5,1} empty_mask", empty_a, 4'b0010);
        chk("model w2 5", pend[0][2], 5);
        chk("model_b w2 sat", pend[1][2], 3);
        alm_empty_wid = 2'd3;
        #1;
        chk("w3 alm_empty", alm_a, 1);

        // Reset mid-operation with traffic held on the inputs
        reset = 1'b0;
        issue_valid = 1'b1; issue_wid = 2'd2;
        commit_valid = 2'b01; commit_wid = {2'd0, 2'd1};
        tick();
        reset = 1'b1;
        idle();
        chk("midreset empty_mask", empty_a, 4'b1111);
        chk("midreset busy", busy_a, 0);
        chk("midreset err a", err_a, 0);
        chk("midreset err b", err_b, 0);
        chk("midreset ready", ready_a, 1);
        tick(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pending_instr_tracker.md
Name: pending_instr_tracker

Overview:
- Per-warp in-flight instruction counter between the issue stage and the execute units.
- Counts instructions issued to execute and not yet committed. Answers the CSR unit's "almost empty" query for one warp.
- Applies issue backpressure when a warp's counter would overflow. Reports a per-warp empty mask and a core busy flag.

Parameters:
- NUM_WARPS, 4, number of warps tracked (≥1).
- NUM_COMMITS, 2, number of commit ports retiring in parallel (≥1).
- CTR_WIDTH, 8, bits per warp counter; max pending = 2^CTR_WIDTH-1.
- ALM_EMPTY, 1, count at which alm_empty asserts (the querying CSR instruction itself).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- issue_valid  in  1  instruction entering execute
- issue_wid  in  NW_WIDTH  warp of issued instruction
- issue_ready  out  1  tracker can accept the issue
- commit_valid  in  NUM_COMMITS  per-port commit fire with eop (one instruction retired)
- commit_wid  in  NUM_COMMITS*NW_WIDTH  warp of each commit
- alm_empty_wid  in  NW_WIDTH  warp being queried
- alm_empty  out  1  pending[alm_empty_wid] == ALM_EMPTY
- empty_mask  out  NUM_WARPS  bit w = pending[w]==0, registered
- busy  out  1  any counter nonzero, registered
- underflow_err  out  1  sticky: commit seen on a zero counter

Behaviour:
- Issue fire = issue_valid && issue_ready.
- Per warp w, each cycle:
  - incr_w = fire && issue_wid==w.
  - decr_w = count of ports p with commit_valid[p] && commit_wid[p]==w, width CLOG2(NUM_COMMITS+1).
  - pending_w <= pending_w + incr_w - decr_w.
  - Arithmetic is in CTR_WIDTH+1 bits before truncation.
- Simultaneous issue and commit on the same warp: net change applied in the same cycle. Example: count 3, one issue and two commits gives 2.
- Several commit ports naming the same warp in one cycle: all are counted.
- issue_ready is combinational, with no dependence on issue_valid:
  - Deasserts when pending[issue_wid] == 2^CTR_WIDTH-1 and no commit targets issue_wid this cycle.
  - A same-cycle commit to that warp frees the slot, so issue_ready stays 1.
- Underflow: if decr_w > pending_w, clamp pending_w to 0 (issue of the same cycle still added). Set underflow_err and hold it until reset. Simulation assertion fires.
- alm_empty is combinational from the registered counters and alm_empty_wid. It does not see same-cycle commits; the one-cycle-conservative answer is acceptable.
- empty_mask and busy are registered from the next-state counters, so they align with the counter update (valid the cycle after the event).
- Latency:
  - Issue or commit to counter visible: 1 cycle.
  - Query to alm_empty: 0 cycles.
- Reset (reset==0 at a clk edge), including mid-operation:
  - All counters cleared to 0, discarding in-flight accounting.
  - empty_mask = all 1s, busy = 0, underflow_err = 0.
  - issue_ready = 1 from the first cycle after reset.
  - Inputs are ignored during reset.
- No FSM. Per-warp state is the counter only; the global state is the sticky error flag.

Decomposition:
- Shared package (VX_gpu_pkg) holds:
  - Counter-width localparam default.
  - ALM_EMPTY constant, shared with the CSR unit so both agree on the threshold.
- One natural sub-module: pending_commit_popcount. Given NUM_COMMITS valid bits and wids plus a target wid, it outputs decr_w. It is instantiated per warp.
- Counter update and flags stay in the top module.

Test Plan:
- Reset then idle: reset low for 2 cycles → empty_mask=4'b1111, busy=0, issue_ready=1, alm_empty=0 for any wid (count 0 ≠ 1).
- Single warp round trip: issue 3 instructions to warp 2, query wid 2 → alm_empty=0; commit 2 on port 0 → next cycle count 1, alm_empty=1; commit 1 more → empty_mask[2]=1, busy=0.
- Concurrent ops: warp 1 at count 3; same cycle issue wid 1, commit port0 wid 1, commit port1 wid 1 → count 2. Both ports committing warp 0 at count 2 → count 0.
- Saturation backpressure, CTR_WIDTH=2:
  - Issue 3 to warp 0 → issue_ready=0 while issue_wid=0, issue_ready=1 for issue_wid=3.
  - Assert a commit on wid 0 with a held issue → issue_ready=1, count stays 3.
- Underflow: commit wid 3 at count 0 → count stays 0, underflow_err=1, and it persists across later traffic until reset.
- Reset mid-operation: warps at counts {2,0,5,1}, assert reset one cycle → all counts 0, empty_mask=1111, underflow_err cleared.
